// File: rtl/ppu_reg_responder_if.sv
// CPU-side register bus between the PPU bus initiator and the register responder.
// Latency: the initiator holds cs as a level; the responder registers read data one clock after the access edge.
// Backpressure: none; the initiator keeps its accesses at least three PPU clocks apart.
interface ppu_reg_responder_if;
    logic       cs;
    logic       rw;
    logic [2:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output cs, rw, address, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  cs, rw, address, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/ppu_reg_responder.sv
// PPU register front-end: decodes $2000-$2007, holds scroll/addr/flag state, issues VRAM/OAM strobes, raises NMI.
// Latency: register effects 1 clk after the cs rising edge; PPUDATA reads take 3 clks (4 with PALETTE_READ_BYPASS_EN).
// Backpressure: none; an access edge that arrives while a PPUDATA read is in flight is dropped.
module ppu_reg_responder #(
    parameter int ADDR_W = 14,
    parameter int OAM_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    ppu_reg_responder_if.slave bus,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               sprite0_set,
    input  logic               overflow_set,
    output logic [7:0]         ctrl_reg,
    output logic [7:0]         mask_reg,
    output logic [7:0]         scroll_x,
    output logic [7:0]         scroll_y,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rdata,
    output logic [OAM_W-1:0]   oam_addr,
    output logic [7:0]         oam_wdata,
    output logic               oam_we,
    input  logic [7:0]         oam_rdata,
    output logic               nmi
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE} state_t;

    state_t            state, state_nxt;
    logic              cs_q;
    logic              acc, wr, rd;
    logic              w;
    logic [5:0]        t_hi;
    logic [7:0]        rd_buf;
    logic [7:0]        open_bus;
    logic [7:0]        data_out_q;
    logic              vblank, sprite0, overflow;
    logic              vblank_nxt;
    logic [7:0]        ctrl_nxt;
    logic [ADDR_W-1:0] inc;
`ifdef PALETTE_READ_BYPASS_EN
    logic              pal_q;
`endif

    // Only the first clock of a cs level is an access, and only while no PPUDATA read is in flight.
    assign acc = bus.cs & ~cs_q & (state == IDLE) & ~reset;
    assign wr  = acc & ~bus.rw;
    assign rd  = acc &  bus.rw;

    assign bus.data_oe  = bus.cs & bus.rw;
    assign bus.data_out = data_out_q;

    assign inc      = ctrl_reg[2] ? ADDR_W'(32) : ADDR_W'(1);
    assign ctrl_nxt = (wr && bus.address == 3'd0) ? bus.data_in : ctrl_reg;

    // A STATUS read wins over a simultaneous vblank_set so that frame never sees the flag or an NMI.
    assign vblank_nxt = vblank_clr                    ? 1'b0 :
                        (rd && bus.address == 3'd2)   ? 1'b0 :
                        vblank_set                    ? 1'b1 : vblank;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // vram_re is issued in the access cycle so vram_rdata is valid while in RD_ISSUE.
    always_comb begin
        state_nxt = state;
        vram_re   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd && bus.address == 3'd7) begin
                    state_nxt = RD_ISSUE;
                    vram_re   = 1'b1;
                end
            end
            RD_ISSUE: state_nxt = RD_CAPTURE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q       <= 1'b0;
            w          <= 1'b0;
            t_hi       <= '0;
            rd_buf     <= '0;
            open_bus   <= '0;
            data_out_q <= '0;
            vblank     <= 1'b0;
            sprite0    <= 1'b0;
            overflow   <= 1'b0;
            nmi        <= 1'b0;
            ctrl_reg   <= '0;
            mask_reg   <= '0;
            scroll_x   <= '0;
            scroll_y   <= '0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_we    <= 1'b0;
            oam_addr   <= '0;
            oam_wdata  <= '0;
            oam_we     <= 1'b0;
`ifdef PALETTE_READ_BYPASS_EN
            pal_q      <= 1'b0;
`endif
        end else begin
            cs_q     <= bus.cs;
            vram_we  <= 1'b0;
            oam_we   <= 1'b0;
            vblank   <= vblank_nxt;
            sprite0  <= ~vblank_clr & (sprite0 | sprite0_set);
            overflow <= ~vblank_clr & (overflow | overflow_set);
            ctrl_reg <= ctrl_nxt;
            nmi      <= vblank_nxt & ctrl_nxt[7];

            // Address post-increment lands the clock after the strobe so the strobe sees the old address.
            if (vram_we || state == RD_ISSUE) vram_addr <= vram_addr + inc;
            if (oam_we) oam_addr <= oam_addr + OAM_W'(1);
            if (state == RD_ISSUE) rd_buf <= vram_rdata;
`ifdef PALETTE_READ_BYPASS_EN
            if (state == RD_CAPTURE && pal_q) begin
                data_out_q <= rd_buf;
                pal_q      <= 1'b0;
            end
`endif

            if (wr) begin
                open_bus <= bus.data_in;
                unique case (bus.address)
                    3'd1: mask_reg <= bus.data_in;
                    3'd3: oam_addr <= OAM_W'(bus.data_in);
                    3'd4: begin
                        oam_wdata <= bus.data_in;
                        oam_we    <= 1'b1;
                    end
                    3'd5: begin
                        if (w) scroll_y <= bus.data_in;
                        else   scroll_x <= bus.data_in;
                        w <= ~w;
                    end
                    3'd6: begin
                        if (w) vram_addr <= ADDR_W'({t_hi, bus.data_in});
                        else   t_hi      <= bus.data_in[5:0];
                        w <= ~w;
                    end
                    3'd7: begin
                        vram_wdata <= bus.data_in;
                        vram_we    <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (rd) begin
                unique case (bus.address)
                    3'd2: begin
                        data_out_q <= {vblank, sprite0, overflow, open_bus[4:0]};
                        w          <= 1'b0;
                    end
                    3'd4: data_out_q <= oam_rdata;
                    3'd7: begin
`ifdef PALETTE_READ_BYPASS_EN
                        if (vram_addr[13:8] == 6'h3F) pal_q      <= 1'b1;
                        else                          data_out_q <= rd_buf;
`else
                        data_out_q <= rd_buf;
`endif
                    end
                    default: data_out_q <= open_bus;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_responder.sv
// Directed bench for ppu_reg_responder with scoreboards for VRAM/OAM strobes and read data.
module tb_ppu_reg_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        vblank_set, vblank_clr, sprite0_set, overflow_set;
    logic [7:0]  ctrl_reg, mask_reg, scroll_x, scroll_y;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;
    logic        vram_we, vram_re;
    logic [7:0]  oam_addr, oam_wdata, oam_rdata;
    logic        oam_we, nmi;

    int          checks = 0;
    int          errors = 0;
    int          vre_cnt = 0;
    logic [31:0] exp_vwr[$];
    logic [31:0] exp_owr[$];
    logic [31:0] exp_rd[$];

    always #5 clk = ~clk;

    ppu_reg_responder_if bus();

    ppu_reg_responder #(.ADDR_W(14), .OAM_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .vblank_set   (vblank_set),
        .vblank_clr   (vblank_clr),
        .sprite0_set  (sprite0_set),
        .overflow_set (overflow_set),
        .ctrl_reg     (ctrl_reg),
        .mask_reg     (mask_reg),
        .scroll_x     (scroll_x),
        .scroll_y     (scroll_y),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_we      (vram_we),
        .vram_re      (vram_re),
        .vram_rdata   (vram_rdata),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_we       (oam_we),
        .oam_rdata    (oam_rdata),
        .nmi          (nmi)
    );

    // Synchronous VRAM: data for the address sampled with vram_re appears one clock later.
    always @(posedge clk) begin
        if (vram_re)
            vram_rdata <= (vram_addr == 14'h2000) ? 8'hAA :
                          (vram_addr == 14'h2020) ? 8'hBB : 8'h00;
    end

    assign oam_rdata = oam_addr ^ 8'h5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vram_re) vre_cnt++;
        if (vram_we) begin
            if (exp_vwr.size() == 0) chk("vram_we_unexpected", 1, 0);
            else chk("vram_we_addr_data", {10'd0, vram_addr, vram_wdata}, exp_vwr.pop_front());
        end
        if (oam_we) begin
            if (exp_owr.size() == 0) chk("oam_we_unexpected", 1, 0);
            else chk("oam_we_addr_data", {16'd0, oam_addr, oam_wdata}, exp_owr.pop_front());
        end
    end

    task automatic cpu_access(input logic r, input logic [2:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        bus.cs = 1'b1; bus.rw = r; bus.address = a; bus.data_in = d;
        #1 chk("data_oe", {31'd0, bus.data_oe}, {31'd0, r});
        repeat (hold) @(posedge clk);
        #1 bus.cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        cpu_access(1'b0, a, d, 1);
    endtask

    task automatic cpu_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        exp_rd.push_back({24'd0, exp});
        cpu_access(1'b1, a, 8'h00, 1);
        chk(tag, {24'd0, bus.data_out}, exp_rd.pop_front());
    endtask

    task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
        @(posedge clk); #1;
        vblank_set = vs; vblank_clr = vc; sprite0_set = s0; overflow_set = ov;
        @(posedge clk); #1;
        vblank_set = 0; vblank_clr = 0; sprite0_set = 0; overflow_set = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.cs = 0; bus.rw = 0; bus.address = 0; bus.data_in = 0;
        vblank_set = 0; vblank_clr = 0; sprite0_set = 0; overflow_set = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regs", {ctrl_reg, mask_reg, scroll_x, scroll_y}, 0);
        chk("rst_vram", {vram_addr, vram_wdata, vram_we, vram_re}, 0);
        chk("rst_oam", {oam_addr, oam_wdata, oam_we}, 0);
        chk("rst_bus", {bus.data_out, bus.data_oe, nmi}, 0);
        reset = 1'b0;

        // PPUADDR two-byte load, then a PPUDATA write with post-increment
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h08);
        chk("addr_load", vram_addr, 14'h2108);
        exp_vwr.push_back(32'h0021_0855);
        cpu_wr(3'd7, 8'h55);
        chk("addr_inc1", vram_addr, 14'h2109);

        // MASK write and open-bus read of a write-only register
        cpu_wr(3'd1, 8'h3C);
        chk("mask", mask_reg, 8'h3C);
        cpu_rd("open_bus_reg0", 3'd0, 8'h3C);

        // Buffered PPUDATA reads with increment 32
        cpu_wr(3'd0, 8'h04);
        cpu_wr(3'd6, 8'h20);
        cpu_wr(3'd6, 8'h00);
        cpu_rd("data_rd1", 3'd7, 8'h00);
        cpu_rd("data_rd2", 3'd7, 8'hAA);
        chk("addr_inc32", vram_addr, 14'h2040);
        chk("vram_re_count", vre_cnt, 2);

        // vblank NMI, STATUS read clears vblank, nmi and the write toggle
        cpu_wr(3'd0, 8'h80);
        cpu_wr(3'd5, 8'h77);
        chk("nmi_idle", nmi, 0);
        pulse(1, 0, 0, 0);
        chk("nmi_rise", nmi, 1);
        cpu_rd("status_vbl", 3'd2, 8'h97);
        chk("nmi_fall", nmi, 0);
        cpu_wr(3'd5, 8'h33);
        chk("w_cleared", {scroll_x, scroll_y}, 16'h3300);

        // vblank_set coincident with a STATUS read is suppressed
        @(posedge clk); #1;
        bus.cs = 1; bus.rw = 1; bus.address = 3'd2; vblank_set = 1;
        @(posedge clk); #1;
        vblank_set = 0; bus.cs = 0;
        chk("supp_status", bus.data_out, 8'h13);
        chk("supp_nmi", nmi, 0);
        repeat (3) @(posedge clk); #1;
        chk("supp_nmi_late", nmi, 0);
        cpu_rd("supp_status2", 3'd2, 8'h13);

        // Enabling NMI while vblank is already set
        cpu_wr(3'd0, 8'h00);
        pulse(1, 0, 0, 0);
        chk("nmi_masked", nmi, 0);
        cpu_wr(3'd0, 8'h80);
        chk("nmi_on_ctrl", nmi, 1);
        cpu_rd("status_ctrl", 3'd2, 8'h80);

        // Sprite flags, then vblank_clr beating simultaneous sets
        pulse(0, 0, 1, 1);
        cpu_rd("status_spr", 3'd2, 8'h60);
        pulse(1, 1, 1, 1);
        chk("clr_nmi", nmi, 0);
        cpu_rd("status_clr", 3'd2, 8'h00);

        // OAM write at 0xFF wraps; cs held 5 clocks gives one strobe
        cpu_wr(3'd3, 8'hFF);
        exp_owr.push_back(32'h0000_FF12);
        cpu_access(1'b0, 3'd4, 8'h12, 5);
        chk("oam_wrap", oam_addr, 8'h00);
        cpu_rd("oam_rd", 3'd4, 8'h5A);
        chk("oam_no_inc", oam_addr, 8'h00);
        cpu_rd("open_bus_reg1", 3'd1, 8'h12);

        // Reset while in RD_ISSUE
        @(posedge clk); #1;
        bus.cs = 1; bus.rw = 1; bus.address = 3'd7;
        @(posedge clk); #1;
        reset = 1; bus.cs = 0;
        @(posedge clk); #1;
        chk("mid_rst_regs", {ctrl_reg, mask_reg, scroll_x, scroll_y}, 0);
        chk("mid_rst_vram", {vram_addr, vram_wdata, vram_we, vram_re}, 0);
        chk("mid_rst_misc", {oam_addr, bus.data_out, nmi}, 0);
        reset = 0;
        cpu_wr(3'd5, 8'h10);
        cpu_wr(3'd5, 8'h20);
        chk("post_rst_scroll", {scroll_x, scroll_y}, 16'h1020);

        chk("vwr_queue_empty", exp_vwr.size(), 0);
        chk("owr_queue_empty", exp_owr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
